fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter LAT_ADD, default 1, FPU cycles for FPU_ADD/FPU_SUB and any other opcode (≥1).
REQ-002 SHALL have parameter LAT_MUL, default 4, FPU cycles for FPU_MUL (≥1).
REQ-003 SHALL have parameter LAT_DIV, default 12, FPU cycles for FPU_DIV (≥1).
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 reqValid  input  2  per-port request valid; bit i = requester i.
REQ-007 reqReady  output  2  per-port accept; transfer on port i when reqValid[i] && reqReady[i].
REQ-008 reqIn1, reqIn2  input  2 x fp16_t  per-port operands.
REQ-009 reqOp  input  2 x fpuOp_t  per-port opcode.
REQ-010 respValid  output  2  one-hot, one-cycle response strobe to the owning port.
REQ-011 respResult  output  fp16_t  result; respCond, respComps, respFlags  output  condCode_t, fpuComp_t, statusFlag_t  captured FPU side outputs.
REQ-012 flagsSticky  output  statusFlag_t  OR-accumulated status flags; flagsClear  input  1  clears them.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 fpuIn1, fpuIn2  output  fp16_t; op  output  fpuOp_t; start  output  1  drive the shared fpu16.
REQ-015 fpuOut  input  fp16_t; condCodes, statusFlags, comps  input  fpu16 outputs.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 reqReady SHALL be nonzero only in IDLE, and SHALL equal the one-hot grant.
REQ-018 Grant: one valid port wins; both valid -> port not in lastGrant wins; lastGrant updates on accept.
REQ-019 On accept, operands/opcode/port id SHALL be registered; fpuIn1/fpuIn2/op SHALL be driven from these registers until the next accept.
REQ-020 IDLE -> ISSUE on accept; ISSUE lasts 1 cycle with start=1; start SHALL be 0 in every other state.
REQ-021 ISSUE loads counter with LAT(op); WAIT lasts exactly LAT(op) cycles; counter width $clog2(max LAT+1).
REQ-022 In the last WAIT cycle, fpuOut/condCodes/comps/statusFlags SHALL be sampled into response registers.
REQ-023 RESP lasts 1 cycle: respValid[owner]=1, then -> IDLE; accept at cycle k gives respValid at cycle k+LAT+2.
REQ-024 respResult/respCond/respComps/respFlags SHALL hold their value until the next capture.
REQ-025 Responses SHALL have no backpressure; requesters SHALL hold request fields stable while valid and not ready.
REQ-026 flagsSticky |= captured statusFlags at capture; flagsClear and capture in the same cycle -> flagsSticky = captured flags only.
REQ-027 Maximum throughput: one operation per LAT+3 cycles; no overlap of operations.

Reset
REQ-028 With reset low at a clock edge: state IDLE, all outputs 0 (reqReady, respValid, start, busy, data, flagsSticky), lastGrant=1 (port 0 wins first).
REQ-029 Reset during ISSUE/WAIT/RESP SHALL drop the in-flight operation with no respValid ever issued for it.

Structure
REQ-030 fp16_t, fpuOp_t, condCode_t, statusFlag_t, fpuComp_t and FSM state enum SHALL live in the shared FPU package; LAT defaults as package constants.
REQ-031 fpu16 SHALL be instantiated outside; one sub-module fpu_rr_arb (2-port round-robin grant) is natural.

Verification
REQ-032 Port0 FPU_ADD 0x3C00+0x4000 accepted cycle 0 -> start=1 cycle 1 only, respValid=2'b01 cycle 3, respResult=0x4200.
REQ-033 Both valid cycle 0: port0 FPU_MUL 0x4000*0x4000, port1 FPU_ADD 0x3C00+0x3C00 -> port0 resp cycle 6 =0x4400; port1 accepted cycle 7, resp cycle 10 =0x4000.
REQ-034 Both ports continuously valid for 4 ops -> grant order 0,1,0,1.
REQ-035 Port1 FPU_DIV 0x3C00/0x0000 -> respResult=0x7C00, DZ set in respFlags and flagsSticky; following FPU_ADD keeps DZ sticky; flagsClear -> flagsSticky=0.
REQ-036 Reset low during WAIT of FPU_DIV -> next cycle all outputs 0, no respValid; new request after reset release served normally.
REQ-037 FPU_ADD with NaN operand 0x7E00 -> NV set in respFlags and flagsSticky.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU types for the two-port fpu16 arbiter: operand/opcode/flag types,
// arbiter FSM states and default per-opcode latencies.
package fpu_arbiter_pkg;

   typedef logic [15:0] fp16_t;

   typedef enum logic [2:0] {
      FPU_ADD = 3'd0,
      FPU_SUB = 3'd1,
      FPU_MUL = 3'd2,
      FPU_DIV = 3'd3,
      FPU_MIN = 3'd4,
      FPU_MAX = 3'd5,
      FPU_CMP = 3'd6,
      FPU_NEG = 3'd7
   } fpuOp_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } condCode_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
      logic un;
   } fpuComp_t;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } statusFlag_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arbState_t;

   localparam int LAT_ADD_DEFAULT = 1;
   localparam int LAT_MUL_DEFAULT = 4;
   localparam int LAT_DIV_DEFAULT = 12;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Two-port round-robin grant: a lone requester always wins, a tie goes to
// the port that was not granted last.
module fpu_rr_arb (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] reqValid,
   output logic [1:0] grant
);

   logic lastGrant;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (reqValid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Any nonzero grant is an accept, since grant only covers valid ports.
   always_ff @(posedge clock) begin
      if (!reset) begin
         lastGrant <= 1'b1;
      end else if (grant != 2'b00) begin
         lastGrant <= grant[1];
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one external fpu16 between two requesters: accept, issue, wait for
// the opcode's fixed latency, then return the captured result to the owner.
module fpu_arbiter
   import fpu_arbiter_pkg::*;
#(
   parameter int LAT_ADD = LAT_ADD_DEFAULT,
   parameter int LAT_MUL = LAT_MUL_DEFAULT,
   parameter int LAT_DIV = LAT_DIV_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  reqValid,
   output logic [1:0]  reqReady,
   input  fp16_t       reqIn1 [2],
   input  fp16_t       reqIn2 [2],
   input  fpuOp_t      reqOp [2],
   output logic [1:0]  respValid,
   output fp16_t       respResult,
   output condCode_t   respCond,
   output fpuComp_t    respComps,
   output statusFlag_t respFlags,
   output statusFlag_t flagsSticky,
   input  logic        flagsClear,
   output logic        busy,
   output fp16_t       fpuIn1,
   output fp16_t       fpuIn2,
   output fpuOp_t      op,
   output logic        start,
   input  fp16_t       fpuOut,
   input  condCode_t   condCodes,
   input  statusFlag_t statusFlags,
   input  fpuComp_t    comps
);

   localparam int LAT_MAX = maxOf3(LAT_ADD, LAT_MUL, LAT_DIV);
   localparam int CW      = $clog2(LAT_MAX + 1);

   arbState_t     state;
   logic          owner;
   logic [CW-1:0] cnt;
   logic [1:0]    grant;
   logic          accept;
   logic          capture;

   function automatic logic [CW-1:0] latOf(input fpuOp_t o);
      case (o)
         FPU_MUL: latOf = CW'(LAT_MUL);
         FPU_DIV: latOf = CW'(LAT_DIV);
         default: latOf = CW'(LAT_ADD);
      endcase
   endfunction

   fpu_rr_arb u_arb (
      .clock    (clock),
      .reset    (reset),
      .enable   (reset && (state == IDLE)),
      .reqValid (reqValid),
      .grant    (grant)
   );

   assign reqReady = grant;
   assign accept   = (grant != 2'b00);
   assign capture  = (state == WAIT) && (cnt == CW'(1));

   // The FPU operand/opcode outputs are the accept registers themselves, so
   // they stay put from one accept to the next.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         cnt         <= '0;
         fpuIn1      <= '0;
         fpuIn2      <= '0;
         op          <= FPU_ADD;
         start       <= 1'b0;
         busy        <= 1'b0;
         respValid   <= 2'b00;
         respResult  <= '0;
         respCond    <= '0;
         respComps   <= '0;
         respFlags   <= '0;
         flagsSticky <= '0;
      end else begin
         start     <= 1'b0;
         respValid <= 2'b00;
         case (state)
            IDLE: begin
               if (accept) begin
                  owner  <= grant[1];
                  fpuIn1 <= reqIn1[grant[1]];
                  fpuIn2 <= reqIn2[grant[1]];
                  op     <= reqOp[grant[1]];
                  start  <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= latOf(op);
               state <= WAIT;
            end
            WAIT: begin
               if (capture) begin
                  respResult <= fpuOut;
                  respCond   <= condCodes;
                  respComps  <= comps;
                  respFlags  <= statusFlags;
                  respValid  <= owner ? 2'b10 : 2'b01;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A clear coinciding with a capture keeps only the fresh flags.
         if (capture) begin
            flagsSticky <= (flagsClear ? '0 : flagsSticky) | statusFlags;
         end else if (flagsClear) begin
            flagsSticky <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: a stand-in fpu16 with per-opcode latency, a
// scoreboard filled on accept and drained on respValid, and scenario tasks.
module tb_fpu_arbiter;
   import fpu_arbiter_pkg::*;

   localparam int LAT_A = 1;
   localparam int LAT_M = 4;
   localparam int LAT_D = 12;

   typedef struct {
      int          port;
      fp16_t       res;
      statusFlag_t flags;
      condCode_t   cond;
      fpuComp_t    comp;
      int          due;
   } exp_t;

   typedef struct {
      int          port;
      int          cyc;
      fp16_t       res;
      statusFlag_t flags;
   } ev_t;

   typedef struct {
      fpuOp_t o;
      fp16_t  a;
      fp16_t  b;
   } req_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   fp16_t       reqIn1 [2];
   fp16_t       reqIn2 [2];
   fpuOp_t      reqOp [2];
   logic [1:0]  respValid;
   fp16_t       respResult;
   condCode_t   respCond;
   fpuComp_t    respComps;
   statusFlag_t respFlags;
   statusFlag_t flagsSticky;
   logic        flagsClear;
   logic        busy;
   fp16_t       fpuIn1;
   fp16_t       fpuIn2;
   fpuOp_t      op;
   logic        start;
   fp16_t       fpuOut;
   condCode_t   condCodes;
   statusFlag_t statusFlags;
   fpuComp_t    comps;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int startDue = -1;

   exp_t sb[$];
   ev_t  acceptLog[$];
   ev_t  respLog[$];
   req_t pq0[$];
   req_t pq1[$];

   fpu_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .reqValid    (reqValid),
      .reqReady    (reqReady),
      .reqIn1      (reqIn1),
      .reqIn2      (reqIn2),
      .reqOp       (reqOp),
      .respValid   (respValid),
      .respResult  (respResult),
      .respCond    (respCond),
      .respComps   (respComps),
      .respFlags   (respFlags),
      .flagsSticky (flagsSticky),
      .flagsClear  (flagsClear),
      .busy        (busy),
      .fpuIn1      (fpuIn1),
      .fpuIn2      (fpuIn2),
      .op          (op),
      .start       (start),
      .fpuOut      (fpuOut),
      .condCodes   (condCodes),
      .statusFlags (statusFlags),
      .comps       (comps)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic bit isNaN(input fp16_t x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
   endfunction

   function automatic int latFor(input fpuOp_t o);
      if (o == FPU_MUL) return LAT_M;
      if (o == FPU_DIV) return LAT_D;
      return LAT_A;
   endfunction

   function automatic fp16_t refResult(input fpuOp_t o, input fp16_t a, input fp16_t b);
      if (isNaN(a) || isNaN(b)) return 16'h7E00;
      case (o)
         FPU_ADD: begin
            if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
            if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
         end
         FPU_MUL: if (a == 16'h4000 && b == 16'h4000) return 16'h4400;
         FPU_DIV: if (b == 16'h0000) return {a[15] ^ b[15], 15'h7C00};
         default: ;
      endcase
      return a ^ {b[7:0], b[15:8]} ^ {13'h0, o};
   endfunction

   function automatic statusFlag_t refFlags(input fpuOp_t o, input fp16_t a, input fp16_t b);
      statusFlag_t f;
      f = '0;
      if (isNaN(a) || isNaN(b)) f.nv = 1'b1;
      else if (o == FPU_DIV && b == 16'h0000) f.dz = 1'b1;
      return f;
   endfunction

   function automatic condCode_t refCond(input fp16_t r);
      condCode_t c;
      c = '0;
      c.n = r[15];
      c.z = (r[14:0] == 15'h0);
      return c;
   endfunction

   function automatic fpuComp_t refComp(input fp16_t a, input fp16_t b);
      fpuComp_t c;
      c = '0;
      c.un = isNaN(a) || isNaN(b);
      c.eq = !c.un && (a == b);
      c.lt = !c.un && (a < b);
      c.gt = !c.un && (a > b);
      return c;
   endfunction

   // Stand-in fpu16: results are only meaningful in the single cycle that
   // is the arbiter's last WAIT cycle; otherwise it drives junk.
   int          fpuCnt = 0;
   fp16_t       mRes;
   statusFlag_t mFlags;
   condCode_t   mCond;
   fpuComp_t    mComp;

   always @(posedge clock) begin
      if (start) begin
         fpuCnt <= latFor(op);
         mRes   <= refResult(op, fpuIn1, fpuIn2);
         mFlags <= refFlags(op, fpuIn1, fpuIn2);
         mCond  <= refCond(refResult(op, fpuIn1, fpuIn2));
         mComp  <= refComp(fpuIn1, fpuIn2);
      end else if (fpuCnt != 0) begin
         fpuCnt <= fpuCnt - 1;
      end
   end

   assign fpuOut      = (fpuCnt == 1) ? mRes   : 16'hDEAD;
   assign statusFlags = (fpuCnt == 1) ? mFlags : '1;
   assign condCodes   = (fpuCnt == 1) ? mCond  : '1;
   assign comps       = (fpuCnt == 1) ? mComp  : '1;

   // Monitor: pushes expectations on accept, checks start timing and the
   // idle-only ready rule, and pops/compares on every response strobe.
   always @(negedge clock) begin : monitor
      exp_t e;
      ev_t  ev;
      if (reset) begin
         if (start || cyc == startDue) begin
            compared++;
            if (start !== (cyc == startDue)) begin
               mismatched++;
               $display("[TB] FAIL start_pulse: cycle %0d start=%b required=%b", cyc, start, (cyc == startDue));
            end
         end
         if (reqReady !== 2'b00) begin
            compared++;
            if (busy !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL ready_in_idle: cycle %0d reqReady=%b busy=%b required busy=0", cyc, reqReady, busy);
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (reqValid[i] && reqReady[i]) begin
               e.port  = i;
               e.res   = refResult(reqOp[i], reqIn1[i], reqIn2[i]);
               e.flags = refFlags(reqOp[i], reqIn1[i], reqIn2[i]);
               e.cond  = refCond(e.res);
               e.comp  = refComp(reqIn1[i], reqIn2[i]);
               e.due   = cyc + latFor(reqOp[i]) + 2;
               sb.push_back(e);
               ev.port  = i;
               ev.cyc   = cyc;
               ev.res   = '0;
               ev.flags = '0;
               acceptLog.push_back(ev);
               startDue = cyc + 1;
            end
         end
         if (respValid !== 2'b00) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_resp: cycle %0d respValid=%b required none", cyc, respValid);
            end else begin
               e = sb.pop_front();
               compared++;
               if (respValid !== ((e.port == 1) ? 2'b10 : 2'b01)) begin
                  mismatched++;
                  $display("[TB] FAIL resp_port: respValid=%b required port %0d", respValid, e.port);
               end
               compared++;
               if (cyc !== e.due) begin
                  mismatched++;
                  $display("[TB] FAIL resp_cycle: got cycle %0d required %0d", cyc, e.due);
               end
               compared++;
               if (respResult !== e.res) begin
                  mismatched++;
                  $display("[TB] FAIL resp_result: got %h required %h", respResult, e.res);
               end
               compared++;
               if ({respFlags, respCond, respComps} !== {e.flags, e.cond, e.comp}) begin
                  mismatched++;
                  $display("[TB] FAIL resp_side: got flags=%b cond=%b comps=%b required flags=%b cond=%b comps=%b",
                           respFlags, respCond, respComps, e.flags, e.cond, e.comp);
               end
               ev.port  = (respValid == 2'b10) ? 1 : 0;
               ev.cyc   = cyc;
               ev.res   = respResult;
               ev.flags = respFlags;
               respLog.push_back(ev);
            end
         end
      end
   end

   task automatic runTraffic(input int budget);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done) begin
         @(posedge clock);
         #1;
         reqValid[0] = (pq0.size() != 0);
         if (pq0.size() != 0) begin
            reqOp[0] = pq0[0].o; reqIn1[0] = pq0[0].a; reqIn2[0] = pq0[0].b;
         end
         reqValid[1] = (pq1.size() != 0);
         if (pq1.size() != 0) begin
            reqOp[1] = pq1[0].o; reqIn1[1] = pq1[0].a; reqIn2[1] = pq1[0].b;
         end
         @(negedge clock);
         if (reqValid[0] && reqReady[0]) void'(pq0.pop_front());
         if (reqValid[1] && reqReady[1]) void'(pq1.pop_front());
         #1;
         n++;
         if (pq0.size() == 0 && pq1.size() == 0 && sb.size() == 0) begin
            done = 1'b1;
         end else if (n >= budget) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL traffic_timeout: %0d cycles, pending p0=%0d p1=%0d sb=%0d required 0",
                     n, pq0.size(), pq1.size(), sb.size());
            pq0.delete();
            pq1.delete();
            sb.delete();
            done = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      reqValid = 2'b00;
   endtask

   task automatic pulseClear();
      @(posedge clock);
      #1;
      flagsClear = 1'b1;
      @(posedge clock);
      #1;
      flagsClear = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      reqValid   = 2'b00;
      flagsClear = 1'b0;
      for (int i = 0; i < 2; i++) begin
         reqIn1[i] = '0;
         reqIn2[i] = '0;
         reqOp[i]  = FPU_ADD;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      compared++;
      if ({reqReady, respValid, start, busy} !== 6'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ctrl: got %b required 0", {reqReady, respValid, start, busy});
      end
      compared++;
      if ({respResult, respCond, respComps, respFlags} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_resp: got %h required 0", {respResult, respCond, respComps, respFlags});
      end
      compared++;
      if ({flagsSticky, fpuIn1, fpuIn2, op} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: got %h required 0", {flagsSticky, fpuIn1, fpuIn2, op});
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_arbitration();
      int base;
      acceptLog.delete();
      respLog.delete();
      pq0.push_back('{FPU_MUL, 16'h4000, 16'h4000});
      pq1.push_back('{FPU_ADD, 16'h3C00, 16'h3C00});
      runTraffic(60);
      compared++;
      if (acceptLog.size() != 2 || respLog.size() != 2) begin
         mismatched++;
         $display("[TB] FAIL arb_counts: accepts=%0d resps=%0d required 2/2", acceptLog.size(), respLog.size());
      end else begin
         base = acceptLog[0].cyc;
         compared++;
         if (acceptLog[0].port !== 0 || acceptLog[1].port !== 1) begin
            mismatched++;
            $display("[TB] FAIL arb_first_grant: order %0d,%0d required 0,1", acceptLog[0].port, acceptLog[1].port);
         end
         compared++;
         if (acceptLog[1].cyc - base !== 7) begin
            mismatched++;
            $display("[TB] FAIL arb_second_accept: offset %0d required 7", acceptLog[1].cyc - base);
         end
         compared++;
         if (respLog[0].cyc - base !== 6 || respLog[0].res !== 16'h4400) begin
            mismatched++;
            $display("[TB] FAIL arb_mul_resp: offset %0d value %h required 6 / 4400", respLog[0].cyc - base, respLog[0].res);
         end
         compared++;
         if (respLog[1].cyc - base !== 10 || respLog[1].res !== 16'h4000) begin
            mismatched++;
            $display("[TB] FAIL arb_add_resp: offset %0d value %h required 10 / 4000", respLog[1].cyc - base, respLog[1].res);
         end
      end
   endtask

   task automatic test_back_to_back();
      acceptLog.delete();
      respLog.delete();
      pq0.push_back('{FPU_ADD, 16'h1111, 16'h2222});
      pq0.push_back('{FPU_ADD, 16'h3333, 16'h4444});
      pq1.push_back('{FPU_SUB, 16'h5555, 16'h6666});
      pq1.push_back('{FPU_ADD, 16'h7777, 16'h0101});
      runTraffic(60);
      compared++;
      if (acceptLog.size() != 4 || respLog.size() != 4) begin
         mismatched++;
         $display("[TB] FAIL b2b_counts: accepts=%0d resps=%0d required 4/4", acceptLog.size(), respLog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            compared++;
            if (acceptLog[i].port !== (i % 2)) begin
               mismatched++;
               $display("[TB] FAIL b2b_order: grant %0d went to port %0d required %0d", i, acceptLog[i].port, i % 2);
            end
         end
         for (int i = 1; i < 4; i++) begin
            compared++;
            if (acceptLog[i].cyc - acceptLog[i-1].cyc !== LAT_A + 3) begin
               mismatched++;
               $display("[TB] FAIL b2b_spacing: gap %0d required %0d", acceptLog[i].cyc - acceptLog[i-1].cyc, LAT_A + 3);
            end
         end
      end
   endtask

   task automatic test_single_add();
      acceptLog.delete();
      respLog.delete();
      pq0.push_back('{FPU_ADD, 16'h3C00, 16'h4000});
      runTraffic(30);
      compared++;
      if (respLog.size() != 1 || acceptLog.size() != 1) begin
         mismatched++;
         $display("[TB] FAIL add_count: resps=%0d required 1", respLog.size());
      end else if (respLog[0].res !== 16'h4200 || respLog[0].port !== 0 ||
                   respLog[0].cyc - acceptLog[0].cyc !== 3) begin
         mismatched++;
         $display("[TB] FAIL add_resp: value %h port %0d offset %0d required 4200 / 0 / 3",
                  respLog[0].res, respLog[0].port, respLog[0].cyc - acceptLog[0].cyc);
      end
   endtask

   task automatic test_div_flags();
      statusFlag_t dzOnly;
      dzOnly = '0;
      dzOnly.dz = 1'b1;
      pulseClear();
      respLog.delete();
      pq1.push_back('{FPU_DIV, 16'h3C00, 16'h0000});
      runTraffic(40);
      compared++;
      if (respLog.size() != 1 || respLog[0].res !== 16'h7C00 || respLog[0].flags !== dzOnly) begin
         mismatched++;
         $display("[TB] FAIL div_resp: count %0d value %h flags %b required 1 / 7C00 / %b",
                  respLog.size(), (respLog.size() > 0) ? respLog[0].res : 16'h0,
                  (respLog.size() > 0) ? respLog[0].flags : statusFlag_t'('0), dzOnly);
      end
      compared++;
      if (flagsSticky !== dzOnly) begin
         mismatched++;
         $display("[TB] FAIL div_sticky: got %b required %b", flagsSticky, dzOnly);
      end
      pq0.push_back('{FPU_ADD, 16'h3C00, 16'h4000});
      runTraffic(30);
      compared++;
      if (flagsSticky !== dzOnly) begin
         mismatched++;
         $display("[TB] FAIL sticky_hold: got %b required %b", flagsSticky, dzOnly);
      end
      pulseClear();
      compared++;
      if (flagsSticky !== '0) begin
         mismatched++;
         $display("[TB] FAIL sticky_clear: got %b required 0", flagsSticky);
      end
   endtask

   task automatic test_nan();
      respLog.delete();
      pq0.push_back('{FPU_ADD, 16'h7E00, 16'h3C00});
      runTraffic(30);
      compared++;
      if (respLog.size() != 1 || respLog[0].flags.nv !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL nan_resp_flag: count %0d required 1 with NV", respLog.size());
      end
      compared++;
      if (flagsSticky.nv !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL nan_sticky: got %b required NV set", flagsSticky);
      end
   endtask

   task automatic test_reset_midflight();
      bit got;
      acceptLog.delete();
      respLog.delete();
      @(posedge clock);
      #1;
      reqValid  = 2'b01;
      reqOp[0]  = FPU_DIV;
      reqIn1[0] = 16'h3C00;
      reqIn2[0] = 16'h4000;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clock);
         if (reqReady[0]) got = 1'b1;
      end
      compared++;
      if (!got) begin
         mismatched++;
         $display("[TB] FAIL midflight_accept: no accept within 20 cycles required accept");
      end
      @(posedge clock);
      #1;
      reqValid = 2'b00;
      repeat (3) @(posedge clock);
      #1;
      compared++;
      if (busy !== 1'b1 || respValid !== 2'b00) begin
         mismatched++;
         $display("[TB] FAIL midflight_busy: busy=%b respValid=%b required 1 / 00", busy, respValid);
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
      sb.delete();
      startDue = -1;
      @(negedge clock);
      compared++;
      if ({reqReady, respValid, start, busy} !== 6'b0) begin
         mismatched++;
         $display("[TB] FAIL midflight_ctrl: got %b required 0", {reqReady, respValid, start, busy});
      end
      compared++;
      if ({respResult, respCond, respComps, respFlags, flagsSticky} !== '0) begin
         mismatched++;
         $display("[TB] FAIL midflight_resp: got %h required 0", {respResult, respCond, respComps, respFlags, flagsSticky});
      end
      compared++;
      if ({fpuIn1, fpuIn2, op} !== '0) begin
         mismatched++;
         $display("[TB] FAIL midflight_data: got %h required 0", {fpuIn1, fpuIn2, op});
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      compared++;
      if (respLog.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL midflight_dropped: %0d responses required 0", respLog.size());
      end
      pq1.push_back('{FPU_ADD, 16'h3C00, 16'h3C00});
      runTraffic(30);
      compared++;
      if (respLog.size() != 1 || respLog[0].port !== 1 || respLog[0].res !== 16'h4000) begin
         mismatched++;
         $display("[TB] FAIL post_reset_req: count %0d required 1 response 4000 on port 1", respLog.size());
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_arbitration();
      test_back_to_back();
      test_single_add();
      test_div_flags();
      test_nan();
      test_reset_midflight();
      repeat (2) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
